vector_wb_collector: RTL and testbench
======================================

# vector_wb_collector

Writeback collector sitting between the vector ALU result ports (VSFX 1-cycle, VCFX 3-cycle, VFPU 4-cycle latency) and the single shared vector register-file write port. It absorbs simultaneous result arrivals from units of different latency into an in-order multi-write buffer. It drains one result per granted cycle, with VSCR saturation update. It also issues credit-based hold back to the issue stage so the buffer never overflows.

## Interface
- DEPTH, 8: buffer entries (≥4); also max outstanding (issued but not written) instructions.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_VALU_cs  in  2  issue select to ALU this cycle; nonzero = one instruction issued (01 VSFX, 10 VCFX, 11 VFPU).
- in_VSFX_RFTargetRegEn / in_VCFX_RFTargetRegEn / in_VFPU_RFTargetRegEn  in  1 each  result valid.
- in_VSFX_RFTargetRegister / in_VCFX_… / in_VFPU_…  in  5 each  target VR [0:4].
- in_VSFX_RFResult / in_VCFX_… / in_VFPU_…  in  128 each  result [0:127].
- in_VSFX_Sat / in_VCFX_Sat / in_VFPU_Sat  in  1 each  saturation flag.
- in_RFWrGnt  in  1  RF port granted to vector ALU this cycle (port shared with load unit).
- WB_RFWrEn  out  1  write request/valid.
- WB_RFWrAddr  out  5  write address.
- WB_RFWrData  out  128  write data.
- WB_VSCREn  out  1  VSCR[SAT] update strobe.
- WB_VSCRData  out  1  sat bit to OR into VSCR[SAT].
- WB_Hold  out  1  issue stage must not issue while 1.
- WB_Overflow  out  1  sticky protocol-error flag.

## Operation
- Buffer: circular, DEPTH entries of {addr[0:4], data[0:127], sat}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- Enqueue: up to 3 arrivals per cycle, written at consecutive tail slots in age order VFPU, VCFX, VSFX (VFPU result in a given cycle was issued earliest); tail advances by number of valid arrivals.
- Dequeue: WB_RFWrEn = (count≠0); WB_RFWrAddr/Data = head entry; pop when WB_RFWrEn & in_RFWrGnt.
- Simultaneous enqueue+pop: count_next = count + arrivals − pop; an arrival into an empty buffer is never bypassed.
- VSCR: WB_VSCREn = WB_RFWrEn & in_RFWrGnt; WB_VSCRData = head.sat & WB_VSCREn.
- Credits: pending (0..DEPTH) counts instructions issued and not yet popped; +1 when in_VALU_cs≠0, −1 on pop, both → unchanged. pending ≥ count always.
- WB_Hold = (pending == DEPTH), from registered pending only.
- Protocol violation: issue while WB_Hold=1, or enqueue with no free slot → arrival(s) beyond capacity dropped, pending saturates at DEPTH, WB_Overflow set and held until reset. Valid arrival with pending==0 also sets WB_Overflow (and is enqueued if room).
- Target register 0 is legal; validity comes only from the *_RFTargetRegEn inputs.

## Timing
- Reset (async, active-high): head=tail=count=pending=0; WB_RFWrEn=0, WB_RFWrAddr=0, WB_RFWrData=0, WB_VSCREn=0, WB_VSCRData=0, WB_Hold=0, WB_Overflow=0; buffer contents don't-care. Reset mid-drain discards all entries and in-flight credits.
- Latency: result valid at edge N → WB_RFWrEn earliest in cycle N+1 (combinational outputs from registered buffer state). Issue-to-RF-write: VSFX 2, VCFX 4, VFPU 5 cycles with grant and empty buffer.
- Throughput: one write per granted cycle; grant held low stalls the head indefinitely with outputs stable.
- WB_Hold visible the cycle after the issue that fills credits; deasserts the cycle after the pop that frees one.
- Worst-case burst: VFPU at t, VCFX at t+1, VSFX at t+3 all arrive in the same cycle → 3 enqueues in one edge.

## Test plan
- Single VSFX issue, tgt 5, data 0x…01, grant=1 → WB_RFWrEn one cycle, addr 5, data 0x…01, pending 1→0.
- VFPU t=0 (tgt 1), VCFX t=1 (tgt 2), VSFX t=3 (tgt 3), grant=1 → writes addr 1,2,3 on three consecutive cycles starting t=5.
- Grant held 0, issue 8 VSFX back-to-back (DEPTH=8) → WB_Hold=1 after 8th issue, count 8, no overflow; release grant → 8 writes in order, Hold drops after first pop.
- VCFX result with sat=1, grant=1 → WB_VSCREn=1, WB_VSCRData=1 same cycle as write; grant=0 that cycle → both 0 until granted.
- Issue while WB_Hold=1 → WB_Overflow=1 sticky, pending stays 8, buffered data intact.
- Assert rst with 3 entries buffered, grant=0 → all outputs 0 immediately; after release, no writes emerge.

Source files
------------

// File: rtl/vector_wb_collector_if.sv
// Bundle of vector ALU result ports, issue select, RF write port and status flags.
interface vector_wb_collector_if;
   logic [1:0]   in_VALU_cs;
   logic         in_VSFX_RFTargetRegEn;
   logic         in_VCFX_RFTargetRegEn;
   logic         in_VFPU_RFTargetRegEn;
   logic [0:4]   in_VSFX_RFTargetRegister;
   logic [0:4]   in_VCFX_RFTargetRegister;
   logic [0:4]   in_VFPU_RFTargetRegister;
   logic [0:127] in_VSFX_RFResult;
   logic [0:127] in_VCFX_RFResult;
   logic [0:127] in_VFPU_RFResult;
   logic         in_VSFX_Sat;
   logic         in_VCFX_Sat;
   logic         in_VFPU_Sat;
   logic         in_RFWrGnt;
   logic         WB_RFWrEn;
   logic [0:4]   WB_RFWrAddr;
   logic [0:127] WB_RFWrData;
   logic         WB_VSCREn;
   logic         WB_VSCRData;
   logic         WB_Hold;
   logic         WB_Overflow;

   // Collector side
   modport slave (
      input  in_VALU_cs,
      input  in_VSFX_RFTargetRegEn, in_VCFX_RFTargetRegEn, in_VFPU_RFTargetRegEn,
      input  in_VSFX_RFTargetRegister, in_VCFX_RFTargetRegister, in_VFPU_RFTargetRegister,
      input  in_VSFX_RFResult, in_VCFX_RFResult, in_VFPU_RFResult,
      input  in_VSFX_Sat, in_VCFX_Sat, in_VFPU_Sat,
      input  in_RFWrGnt,
      output WB_RFWrEn, WB_RFWrAddr, WB_RFWrData, WB_VSCREn, WB_VSCRData,
      output WB_Hold, WB_Overflow
   );

   // ALU / issue / RF side
   modport master (
      output in_VALU_cs,
      output in_VSFX_RFTargetRegEn, in_VCFX_RFTargetRegEn, in_VFPU_RFTargetRegEn,
      output in_VSFX_RFTargetRegister, in_VCFX_RFTargetRegister, in_VFPU_RFTargetRegister,
      output in_VSFX_RFResult, in_VCFX_RFResult, in_VFPU_RFResult,
      output in_VSFX_Sat, in_VCFX_Sat, in_VFPU_Sat,
      output in_RFWrGnt,
      input  WB_RFWrEn, WB_RFWrAddr, WB_RFWrData, WB_VSCREn, WB_VSCRData,
      input  WB_Hold, WB_Overflow
   );
endinterface

// File: rtl/vector_wb_collector.sv
// In-order writeback buffer between the vector ALU result ports and the shared
// register-file write port, with credit-based issue hold.
module vector_wb_collector #(
   parameter int unsigned DEPTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   vector_wb_collector_if.slave io_wb
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [0:4]      r_addr [DEPTH];
   logic [0:127]    r_data [DEPTH];
   logic            r_sat  [DEPTH];
   logic [PtrW-1:0] r_head;
   logic [PtrW-1:0] r_tail;
   logic [CntW-1:0] r_count;
   logic [CntW-1:0] r_pending;
   logic            r_overflow;

   // Arrivals indexed in age order: 0 = VFPU (oldest), 1 = VCFX, 2 = VSFX
   logic [2:0]      w_arr_v;
   logic [0:4]      w_arr_addr [3];
   logic [0:127]    w_arr_data [3];
   logic            w_arr_sat  [3];
   logic [2:0]      w_wr_en;
   logic [PtrW-1:0] w_wr_slot  [3];
   logic [1:0]      w_n_acc;
   logic            w_drop;
   logic [CntW-1:0] w_free;
   logic            w_rd_valid;
   logic            w_pop;
   logic            w_issue;
   logic            w_hold;
   logic [CntW-1:0] w_count_nxt;
   logic [CntW-1:0] w_pending_nxt;
   logic            w_ovf_set;

   // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
   function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input logic [1:0] n);
      logic [PtrW+1:0] s;
      s = {2'b00, p} + {{PtrW{1'b0}}, n};
      if (s >= (PtrW + 2)'(DEPTH)) begin
         s = s - (PtrW + 2)'(DEPTH);
      end
      return s[PtrW-1:0];
   endfunction

   assign w_rd_valid = (r_count != '0);
   assign w_pop      = w_rd_valid & io_wb.in_RFWrGnt;
   assign w_issue    = |io_wb.in_VALU_cs;
   assign w_hold     = (r_pending == CntW'(DEPTH));
   assign w_free     = CntW'(DEPTH) - r_count;

   // Gather arrivals and allocate consecutive tail slots, dropping what does not fit
   always_comb begin
      w_arr_v       = {io_wb.in_VSFX_RFTargetRegEn, io_wb.in_VCFX_RFTargetRegEn,
                       io_wb.in_VFPU_RFTargetRegEn};
      w_arr_addr[0] = io_wb.in_VFPU_RFTargetRegister;
      w_arr_addr[1] = io_wb.in_VCFX_RFTargetRegister;
      w_arr_addr[2] = io_wb.in_VSFX_RFTargetRegister;
      w_arr_data[0] = io_wb.in_VFPU_RFResult;
      w_arr_data[1] = io_wb.in_VCFX_RFResult;
      w_arr_data[2] = io_wb.in_VSFX_RFResult;
      w_arr_sat[0]  = io_wb.in_VFPU_Sat;
      w_arr_sat[1]  = io_wb.in_VCFX_Sat;
      w_arr_sat[2]  = io_wb.in_VSFX_Sat;
      w_wr_en       = '0;
      w_n_acc       = '0;
      w_drop        = 1'b0;
      for (int k = 0; k < 3; k++) begin
         w_wr_slot[k] = r_tail;
         if (w_arr_v[k]) begin
            if (CntW'(w_n_acc) < w_free) begin
               w_wr_en[k]   = 1'b1;
               w_wr_slot[k] = ptr_add(r_tail, w_n_acc);
               w_n_acc      = w_n_acc + 2'd1;
            end else begin
               w_drop = 1'b1;
            end
         end
      end
   end

   // Next occupancy, credit count and protocol-error detection
   always_comb begin
      w_count_nxt   = r_count + CntW'(w_n_acc) - CntW'(w_pop);
      w_pending_nxt = r_pending;
      unique case ({w_issue, w_pop})
         2'b10:   if (!w_hold) w_pending_nxt = r_pending + 1'b1;
         2'b01:   if (r_pending != '0) w_pending_nxt = r_pending - 1'b1;
         default: w_pending_nxt = r_pending;
      endcase
      w_ovf_set = (w_issue & w_hold) | w_drop | ((|w_arr_v) & (r_pending == '0));
   end

   // Control state: pointers, occupancy, credits and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_tail     <= ptr_add(r_tail, w_n_acc);
         r_head     <= w_pop ? ptr_add(r_head, 2'd1) : r_head;
         r_count    <= w_count_nxt;
         r_pending  <= w_pending_nxt;
         r_overflow <= r_overflow | w_ovf_set;
      end
   end

   // Buffer storage needs no reset; validity is tracked by r_count
   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (w_wr_en[k]) begin
            r_addr[w_wr_slot[k]] <= w_arr_addr[k];
            r_data[w_wr_slot[k]] <= w_arr_data[k];
            r_sat[w_wr_slot[k]]  <= w_arr_sat[k];
         end
      end
   end

   // Head entry drives the write port; zeroed while empty so reset outputs are clean
   always_comb begin
      io_wb.WB_RFWrEn   = w_rd_valid;
      io_wb.WB_RFWrAddr = '0;
      io_wb.WB_RFWrData = '0;
      io_wb.WB_VSCREn   = w_pop;
      io_wb.WB_VSCRData = w_pop & r_sat[r_head];
      io_wb.WB_Hold     = w_hold;
      io_wb.WB_Overflow = r_overflow;
      if (w_rd_valid) begin
         io_wb.WB_RFWrAddr = r_addr[r_head];
         io_wb.WB_RFWrData = r_data[r_head];
      end
   end
endmodule

// File: tb/tb_vector_wb_collector.sv
// Directed bench for vector_wb_collector: a cycle table plus hand-written
// sequences for credit fill, overflow and reset.
module tb_vector_wb_collector;
   localparam int unsigned Depth = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vector_wb_collector_if u_if();

   vector_wb_collector #(.DEPTH(Depth)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .io_wb (u_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   // en/sat bit 2 = VFPU, bit 1 = VCFX, bit 0 = VSFX
   typedef struct {
      logic [1:0] cs;
      logic [2:0] en;
      logic [4:0] tf;
      logic [4:0] tc;
      logic [4:0] ts;
      logic [2:0] sat;
      logic       gnt;
      logic       x_en;
      logic [4:0] x_addr;
      logic       x_vscren;
      logic       x_vscrd;
      logic       x_hold;
      logic       x_ovf;
   } vec_t;

   vec_t vecs[20];

   function automatic logic [127:0] mk_data(input logic [4:0] t);
      return {32'hCAFE_0000 | {27'h0, t}, 64'h0123_4567_89AB_CDEF, 27'h0, t};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] cs, input logic [2:0] en, input logic [4:0] tf,
                        input logic [4:0] tc, input logic [4:0] ts, input logic [2:0] sat,
                        input logic gnt);
      u_if.in_VALU_cs               = cs;
      u_if.in_VFPU_RFTargetRegEn    = en[2];
      u_if.in_VCFX_RFTargetRegEn    = en[1];
      u_if.in_VSFX_RFTargetRegEn    = en[0];
      u_if.in_VFPU_RFTargetRegister = tf;
      u_if.in_VCFX_RFTargetRegister = tc;
      u_if.in_VSFX_RFTargetRegister = ts;
      u_if.in_VFPU_RFResult         = mk_data(tf);
      u_if.in_VCFX_RFResult         = mk_data(tc);
      u_if.in_VSFX_RFResult         = mk_data(ts);
      u_if.in_VFPU_Sat              = sat[2];
      u_if.in_VCFX_Sat              = sat[1];
      u_if.in_VSFX_Sat              = sat[0];
      u_if.in_RFWrGnt               = gnt;
   endtask

   task automatic check_out(input string tag, input logic x_en, input logic [4:0] x_addr,
                            input logic x_vscren, input logic x_vscrd, input logic x_hold,
                            input logic x_ovf);
      chk({tag, " wren"}, 128'(u_if.WB_RFWrEn), 128'(x_en));
      chk({tag, " addr"}, 128'(u_if.WB_RFWrAddr), x_en ? 128'(x_addr) : 128'h0);
      chk({tag, " data"}, 128'(u_if.WB_RFWrData), x_en ? mk_data(x_addr) : 128'h0);
      chk({tag, " vscren"}, 128'(u_if.WB_VSCREn), 128'(x_vscren));
      chk({tag, " vscrd"}, 128'(u_if.WB_VSCRData), 128'(x_vscrd));
      chk({tag, " hold"}, 128'(u_if.WB_Hold), 128'(x_hold));
      chk({tag, " ovf"}, 128'(u_if.WB_Overflow), 128'(x_ovf));
   endtask

   // Apply one cycle of inputs after the falling edge and sample just after
   task automatic cycle(input string tag, input logic [1:0] cs, input logic [2:0] en,
                        input logic [4:0] ts, input logic gnt, input logic x_en,
                        input logic [4:0] x_addr, input logic x_vscren, input logic x_hold,
                        input logic x_ovf);
      @(negedge clk);
      drive(cs, en, 5'd0, 5'd0, ts, 3'b000, gnt);
      #1;
      check_out(tag, x_en, x_addr, x_vscren, 1'b0, x_hold, x_ovf);
   endtask

   initial begin
      // cs, en, tf, tc, ts, sat, gnt | en, addr, vscren, vscrd, hold, ovf
      vecs[0]  = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{2'b01, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{2'b00, 3'b001, 5'd0, 5'd0, 5'd5, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{2'b11, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{2'b10, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{2'b01, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{2'b00, 3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{2'b01, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{2'b01, 3'b001, 5'd0, 5'd0, 5'd7, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{2'b00, 3'b001, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};

      drive(2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Table: single VSFX, worst-case triple arrival, sat/grant interplay, enq+pop, target 0
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(vecs[i].cs, vecs[i].en, vecs[i].tf, vecs[i].tc, vecs[i].ts, vecs[i].sat,
               vecs[i].gnt);
         #1;
         check_out($sformatf("vec%0d", i), vecs[i].x_en, vecs[i].x_addr, vecs[i].x_vscren,
                   vecs[i].x_vscrd, vecs[i].x_hold, vecs[i].x_ovf);
      end

      // Fill all credits with grant low: 8 VSFX issues, results one cycle behind
      for (int i = 0; i < 8; i++) begin
         cycle($sformatf("fill%0d", i), 2'b01, (i > 0) ? 3'b001 : 3'b000, 5'(10 + i - 1),
               1'b0, (i > 1), 5'd10, 1'b0, 1'b0, 1'b0);
      end
      cycle("full", 2'b00, 3'b001, 5'd17, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1, 1'b0);
      // Issue while held: protocol violation
      cycle("viol", 2'b01, 3'b000, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1, 1'b0);
      cycle("sticky", 2'b00, 3'b000, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1, 1'b1);
      // Release grant: 8 in-order writes, hold drops after the first pop
      for (int i = 0; i < 8; i++) begin
         cycle($sformatf("drain%0d", i), 2'b00, 3'b000, 5'd0, 1'b1, 1'b1, 5'(10 + i), 1'b1,
               (i == 0), 1'b1);
      end
      cycle("drained", 2'b00, 3'b000, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

      // Buffer three entries, then reset asynchronously mid-cycle
      cycle("rb0", 2'b01, 3'b000, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      cycle("rb1", 2'b01, 3'b001, 5'd21, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      cycle("rb2", 2'b01, 3'b001, 5'd22, 1'b0, 1'b1, 5'd21, 1'b0, 1'b0, 1'b1);
      cycle("rb3", 2'b00, 3'b001, 5'd23, 1'b0, 1'b1, 5'd21, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive(2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1);
      rst = 1'b1;
      #1;
      check_out("inrst", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle($sformatf("postrst%0d", i), 2'b00, 3'b000, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0,
               1'b0, 1'b0);
      end

      // Arrival with no outstanding credit flags overflow but is still written
      cycle("nocred", 2'b00, 3'b001, 5'd24, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle("nocred_wr", 2'b00, 3'b000, 5'd0, 1'b1, 1'b1, 5'd24, 1'b1, 1'b0, 1'b1);
      cycle("nocred_end", 2'b00, 3'b000, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
